imem_loader_ctrl: RTL and testbench

Sequencer that owns the instruction memory between reset and program execution. It loads a program from a byte-stream source into the 32-bit instruction memory, holding the core in reset and stalled meanwhile, then hands the memory's read port to the core's program counter. It sits between the boot/debug byte source, the instruction memory write/read ports and the single-cycle core.

---
 rtl/imem_loader_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_imem_loader_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_ctrl.sv
// Instruction memory loader / boot sequencer.
// Assembles a little-endian byte stream into 32-bit words, writes them into the
// instruction memory while holding the core in reset and stalled, then hands the
// memory read port over to the core's program counter.
module imem_loader_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Load request
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  // Byte stream source
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  // Instruction memory write port
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [31:0]       mem_wdata_o,
  // Instruction memory read address and core control
  input  logic [31:0]       cpu_pc_i,
  output logic [31:0]       fetch_addr_o,
  output logic              cpu_reset_o,
  output logic              cpu_stall_o,
  // Status
  output logic              busy_o,
  output logic              running_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StRun   = 2'd3;

  // Largest program that fits the memory: 2^ADDR_W words.
  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              cpu_stall_q, cpu_stall_d;
  logic              busy_q, busy_d;
  logic              running_q, running_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              len_over;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   words_inc;

  // Request length limited to the memory size; oversize requests are flagged.
  always_comb begin
    len_over    = (load_len_i > MaxLen);
    len_clamped = len_over ? MaxLen : load_len_i;
  end

  // Handshake and word counter helpers.
  always_comb begin
    xfer      = byte_valid_i & byte_ready_o;
    words_inc = words_q + 1'b1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    words_d     = words_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    cpu_stall_d = cpu_stall_q;
    busy_d      = busy_q;
    running_d   = running_q;
    err_d       = err_q;

    case (state_q)
      StIdle, StRun: begin
        if (load_start_i) begin
          len_d      = len_clamped;
          err_d      = len_over;
          words_d    = '0;
          byte_cnt_d = 2'd0;
          if (len_clamped == '0) begin
            // Nothing to load: release the core straight away.
            state_d     = StRun;
            running_d   = 1'b1;
            busy_d      = 1'b0;
            cpu_reset_d = 1'b0;
            cpu_stall_d = 1'b0;
          end else begin
            state_d     = StLoad;
            running_d   = 1'b0;
            busy_d      = 1'b1;
            cpu_reset_d = 1'b1;
            cpu_stall_d = 1'b1;
          end
        end
      end

      StLoad: begin
        if (load_start_i) begin
          err_d = 1'b1;
        end
        if (xfer) begin
          shift_d[{byte_cnt_q, 3'b000} +: 8] = byte_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Word complete: present it on the write port during WRITE.
            state_d     = StWrite;
            mem_we_d    = 1'b1;
            mem_waddr_d = words_q[ADDR_W-1:0];
            mem_wdata_d = {byte_data_i, shift_q[23:0]};
          end
        end
      end

      StWrite: begin
        if (load_start_i) begin
          err_d = 1'b1;
        end
        words_d = words_inc;
        if (words_inc == len_q) begin
          state_d     = StRun;
          running_d   = 1'b1;
          busy_d      = 1'b0;
          cpu_reset_d = 1'b0;
          cpu_stall_d = 1'b0;
        end else begin
          state_d = StLoad;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any load in progress immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      len_q       <= '0;
      words_q     <= '0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      cpu_stall_q <= 1'b1;
      busy_q      <= 1'b0;
      running_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      words_q     <= words_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_stall_q <= cpu_stall_d;
      busy_q      <= busy_d;
      running_q   <= running_d;
      err_q       <= err_d;
    end
  end

  // Read-address mux: the core owns the memory only in RUN.
  always_comb begin
    case (state_q)
      StRun:           fetch_addr_o = cpu_pc_i;
      StLoad, StWrite: fetch_addr_o = {{(32 - ADDR_W){1'b0}}, mem_waddr_q};
      default:         fetch_addr_o = '0;
    endcase
  end

  // Byte acceptance decoded directly from state.
  always_comb begin
    byte_ready_o = (state_q == StLoad);
  end

  assign mem_we_o       = mem_we_q;
  assign mem_waddr_o    = mem_waddr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign cpu_reset_o    = cpu_reset_q;
  assign cpu_stall_o    = cpu_stall_q;
  assign busy_o         = busy_q;
  assign running_o      = running_q;
  assign err_o          = err_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Bench for imem_loader_ctrl: a transaction-level model of the loader is checked
// against the DUT every cycle, plus directed literal checks of the key scenarios.
module tb_imem_loader_ctrl;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic [31:0]   cpu_pc = '0;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   fetch_addr;
  logic          cpu_reset;
  logic          cpu_stall;
  logic          busy;
  logic          running;
  logic          err;
  logic [AW:0]   words_loaded;

  imem_loader_ctrl #(.ADDR_W(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_start_i   (load_start),
    .load_len_i     (load_len),
    .byte_valid_i   (byte_valid),
    .byte_data_i    (byte_data),
    .byte_ready_o   (byte_ready),
    .mem_we_o       (mem_we),
    .mem_waddr_o    (mem_waddr),
    .mem_wdata_o    (mem_wdata),
    .cpu_pc_i       (cpu_pc),
    .fetch_addr_o   (fetch_addr),
    .cpu_reset_o    (cpu_reset),
    .cpu_stall_o    (cpu_stall),
    .busy_o         (busy),
    .running_o      (running),
    .err_o          (err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  int run_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Loading is tracked as "bytes collected into the current word" and
  // "a completed word waiting to be written".
  bit          m_loading = 1'b0;
  bit          m_pend    = 1'b0;
  bit          m_run     = 1'b0;
  bit          m_err     = 1'b0;
  int          m_len     = 0;
  int          m_words   = 0;
  int          m_k       = 0;
  logic [31:0] m_word    = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_loading = 1'b0; m_pend = 1'b0; m_run = 1'b0; m_err = 1'b0;
      m_len = 0; m_words = 0; m_k = 0;
    end else if (!m_loading && load_start) begin
      m_err   = (int'(load_len) > 256);
      m_len   = m_err ? 256 : int'(load_len);
      m_words = 0;
      m_k     = 0;
      m_pend  = 1'b0;
      m_run   = (m_len == 0);
      m_loading = !m_run;
    end else if (m_loading) begin
      if (load_start) m_err = 1'b1;
      if (m_pend) begin
        m_pend = 1'b0;
        m_words++;
        if (m_words == m_len) begin
          m_loading = 1'b0;
          m_run     = 1'b1;
        end
      end else if (byte_valid) begin
        m_word[8*m_k +: 8] = byte_data;
        m_k++;
        if (m_k == 4) begin
          m_k    = 0;
          m_pend = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  logic [31:0] w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  bit          prev_run = 1'b0;

  initial forever begin
    @(negedge clk);
    chk("byte_ready",   byte_ready,   m_loading && !m_pend);
    chk("mem_we",       mem_we,       m_pend);
    chk("running",      running,      m_run);
    chk("busy",         busy,         m_loading);
    chk("cpu_reset",    cpu_reset,    !m_run);
    chk("cpu_stall",    cpu_stall,    !m_run);
    chk("err",          err,          m_err);
    chk("words_loaded", words_loaded, m_words);
    if (m_pend) begin
      chk("mem_waddr",  mem_waddr,  m_words % 256);
      chk("mem_wdata",  mem_wdata,  m_word);
      chk("fetch_load", fetch_addr, m_words % 256);
    end
    if (m_run)
      chk("fetch_run", fetch_addr, cpu_pc);
    else if (!m_loading)
      chk("fetch_idle", fetch_addr, 0);
    if (mem_we) begin
      w_addr.push_back(32'(mem_waddr));
      w_data.push_back(mem_wdata);
      w_cyc.push_back(cyc);
    end
    if (running && !prev_run) run_cyc = cyc;
    prev_run = running;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_load(input logic [AW:0] len);
    load_len   = len;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_accept_timeout: byte 0x%0h not taken, required within 50 cycles", b);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] prog [8];
    int b;
    prog[0] = 8'h13; prog[1] = 8'h01; prog[2] = 8'h10; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h20; prog[7] = 8'h00;

    #1 rst = 1'b1;
    settle(3);
    rst = 1'b0;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy",      busy,      0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // Two-word back-to-back load.
    b = w_addr.size();
    start_load(9'd2);
    chk("t1_ready_t1", byte_ready, 1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
    settle(3);
    chk("t1_nwr",   w_addr.size() - b, 2);
    chk("t1_a0",    w_addr[b],         0);
    chk("t1_d0",    w_data[b],         32'h0010_0113);
    chk("t1_c0",    w_cyc[b] - t0,     4);
    chk("t1_a1",    w_addr[b+1],       1);
    chk("t1_d1",    w_data[b+1],       32'h0020_0093);
    chk("t1_c1",    w_cyc[b+1] - t0,   9);
    chk("t1_run",   run_cyc - t0,      10);
    chk("t1_words", words_loaded,      2);

    // RUN passthrough, then restart with gaps between bytes.
    cpu_pc = 32'h0000_000C;
    @(negedge clk);
    chk("t3_fetch",  fetch_addr, 32'h0000_000C);
    chk("t3_creset", cpu_reset,  0);
    chk("t3_cstall", cpu_stall,  0);
    @(posedge clk); #1;
    b = w_addr.size();
    start_load(9'd1);
    chk("t3_restart_reset", cpu_reset, 1);
    chk("t3_restart_busy",  busy,      1);
    send_byte(8'h13, 0);
    send_byte(8'h01, 2);
    send_byte(8'h10, 1);
    send_byte(8'h00, 3);
    settle(4);
    chk("t2_nwr", w_addr.size() - b, 1);
    chk("t2_a0",  w_addr[b],         0);
    chk("t2_d0",  w_data[b],         32'h0010_0113);
    chk("t2_c0",  w_cyc[b] - t0,     10);

    // load_start while busy is ignored but flagged.
    b = w_addr.size();
    start_load(9'd2);
    send_byte(8'h11, 0);
    send_byte(8'h12, 0);
    load_len   = 9'd5;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("t4_err",   err,          1);
    chk("t4_words", words_loaded, 0);
    for (int i = 3; i <= 8; i++) send_byte(8'h10 + 8'(i), 0);
    settle(3);
    chk("t4_nwr",   w_addr.size() - b, 2);
    chk("t4_d0",    w_data[b],         32'h1413_1211);
    chk("t4_d1",    w_data[b+1],       32'h1817_1615);
    chk("t4_words2", words_loaded,     2);
    chk("t4_run",   running,           1);

    // Asynchronous reset mid-word 1.
    b = w_addr.size();
    start_load(9'd2);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_ready",  byte_ready,   0);
    chk("t6_we",     mem_we,       0);
    chk("t6_waddr",  mem_waddr,    0);
    chk("t6_wdata",  mem_wdata,    0);
    chk("t6_creset", cpu_reset,    1);
    chk("t6_cstall", cpu_stall,    1);
    chk("t6_busy",   busy,         0);
    chk("t6_run",    running,      0);
    chk("t6_err",    err,          0);
    chk("t6_words",  words_loaded, 0);
    chk("t6_fetch",  fetch_addr,   0);
    settle(3);
    rst = 1'b0;
    settle(3);
    chk("t6_nwr", w_addr.size() - b, 1);

    // Zero-length load from IDLE.
    b = w_addr.size();
    start_load(9'd0);
    chk("t5_run",  running, 1);
    chk("t5_busy", busy,    0);
    settle(3);
    chk("t5_nwr",  w_addr.size() - b, 0);

    // Oversize request clamps to the full memory.
    b = w_addr.size();
    start_load(9'h101);
    chk("t7_err", err, 1);
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 4; j++)
        send_byte(8'((i * 4 + j) & 8'hFF), 0);
    settle(3);
    chk("t7_nwr",   w_addr.size() - b, 256);
    chk("t7_a0",    w_addr[b],         0);
    chk("t7_alast", w_addr[b+255],     255);
    chk("t7_dlast", w_data[b+255],     32'hFFFE_FDFC);
    chk("t7_words", words_loaded,      256);
    chk("t7_err2",  err,               1);
    chk("t7_run",   running,           1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
